// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and constants for the key press conditioner
// Purpose: per-key FSM state encoding, key count, and a sizing helper.
// Ports: none (package).
package key_cond_pkg;

  localparam int NUM_KEYS = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one key: synchronizer, debounce FSM, repeat timer
// Purpose: debounce a single raw push-button and produce a level plus press/repeat strobes.
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-high reset
//   raw   - asynchronous raw key input
//   level - debounced pressed state (registered)
//   pulse - one-cycle strobe per accepted press and per repeat (registered)
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                  REPEAT_PERIOD_CYCLES)) + 1;
  localparam logic RAW_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          sync_a, sync_b;
  logic          active;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] repeat_term;
  logic          rep_q, rep_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  assign active = (KEY_ACTIVE_LOW != 0) ? ~sync_b : sync_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= RAW_IDLE;
      sync_b  <= RAW_IDLE;
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // rep_q selects between the initial repeat delay and the steady repeat period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    level_d     = level_q;
    pulse_d     = 1'b0;
    repeat_term = rep_q ? CW'(REPEAT_PERIOD_CYCLES - 1) : CW'(REPEAT_DELAY_CYCLES - 1);
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!active) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == repeat_term) begin
          // Timer wraps at its own terminal either way; only the strobe is gated.
          pulse_d = (REPEAT_EN != 0);
          cnt_d   = '0;
          rep_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (active) begin
          state_d = HELD;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - debounced level and press/repeat strobes for three keys
// Purpose: top-level wiring of one independent debounce channel per key.
// Ports:
//   inclk     - sole clock
//   reset     - asynchronous active-high reset
//   key_raw   - raw asynchronous push-button inputs, bit n = key n
//   key_level - debounced pressed state, 1 = pressed
//   key_pulse - one-cycle press strobes plus repeat strobes
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic                inclk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse
);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW      (KEY_ACTIVE_LOW),
      .REPEAT_EN           (REPEAT_EN),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_chan (
      .clk  (inclk),
      .rst  (reset),
      .raw  (key_raw[gi]),
      .level(key_level[gi]),
      .pulse(key_pulse[gi])
    );
  end

endmodule

// File: tb/tb_key_press_conditioner.sv
// tb/tb_key_press_conditioner.sv - self-checking bench for key_press_conditioner
// Purpose: table vectors, directed corner sequences and random stimulus vs a reference model.
// Ports: none (top-level bench).
module tb_key_press_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_raw;
  logic [2:0] lvl_n, pls_n, lvl_r, pls_r;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: two-stage delay of the active level, disagreement
  // run length, accepted level, hold time since (re)entering held, per key.
  bit m_d1[3], m_d2[3], m_lvl[3], m_prev[3], m_pn[3], m_pr[3];
  int m_mis[3], m_t[3];

  always #5 clk = ~clk;

  key_press_conditioner #(
    .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
  ) dut_norep (
    .inclk(clk), .reset(reset), .key_raw(key_raw), .key_level(lvl_n), .key_pulse(pls_n)
  );

  key_press_conditioner #(
    .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
  ) dut_rep (
    .inclk(clk), .reset(reset), .key_raw(key_raw), .key_level(lvl_r), .key_pulse(pls_r)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_d1[k] = 0; m_d2[k] = 0; m_lvl[k] = 0; m_prev[k] = 0;
      m_pn[k] = 0; m_pr[k] = 0; m_mis[k] = 0; m_t[k] = 0;
    end
  endtask

  // Level flips after D+1 consecutive edges disagreeing with it; repeats fire
  // RD edges after acceptance (or after returning from a short release), then every RP.
  task automatic model_edge(input logic [2:0] act);
    for (int k = 0; k < 3; k++) begin
      bit a;
      a = m_d2[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = act[k];
      m_pn[k] = 0;
      m_pr[k] = 0;
      if (a != m_lvl[k]) m_mis[k]++; else m_mis[k] = 0;
      if (a != m_lvl[k] && m_mis[k] == D + 1) begin
        m_lvl[k] = a;
        m_mis[k] = 0;
        if (a) begin
          m_pn[k] = 1; m_pr[k] = 1; m_t[k] = 0;
        end
      end else if (m_lvl[k] && a) begin
        if (!m_prev[k]) m_t[k] = 0; else m_t[k]++;
        if (m_t[k] >= RD && (m_t[k] - RD) % RP == 0) m_pr[k] = 1;
      end
      m_prev[k] = a;
    end
  endtask

  // Called at a negedge; leaves time at a negedge.
  task automatic step(input logic [2:0] act);
    logic [2:0] el, epn, epr;
    key_raw = ~act;
    @(posedge clk);
    model_edge(act);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      el[k] = m_lvl[k]; epn[k] = m_pn[k]; epr[k] = m_pr[k];
    end
    chk("model_level_norep", int'(lvl_n), int'(el));
    chk("model_pulse_norep", int'(pls_n), int'(epn));
    chk("model_level_rep",   int'(lvl_r), int'(el));
    chk("model_pulse_rep",   int'(pls_r), int'(epr));
  endtask

  // Called at a negedge; reset takes effect without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_level_norep", int'(lvl_n), 0);
    chk("reset_pulse_norep", int'(pls_n), 0);
    chk("reset_level_rep",   int'(lvl_r), 0);
    chk("reset_pulse_rep",   int'(pls_r), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] act;
    logic [2:0] lvl;
    logic [2:0] pls;
  } vec_t;

  vec_t tbl[16];
  bit   cur[3];
  int   run[3];
  int   pcount;

  initial begin
    // key0 held; key1 bouncing 3/1/3; key2 held, released 2 edges, pressed again
    tbl[0]  = '{3'b111, 3'b000, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b000};
    tbl[2]  = '{3'b111, 3'b000, 3'b000};
    tbl[3]  = '{3'b101, 3'b000, 3'b000};
    tbl[4]  = '{3'b111, 3'b000, 3'b000};
    tbl[5]  = '{3'b111, 3'b000, 3'b000};
    tbl[6]  = '{3'b111, 3'b101, 3'b101};
    tbl[7]  = '{3'b101, 3'b101, 3'b000};
    tbl[8]  = '{3'b001, 3'b101, 3'b000};
    tbl[9]  = '{3'b001, 3'b101, 3'b000};
    for (int i = 10; i < 16; i++) tbl[i] = '{3'b101, 3'b101, 3'b000};

    reset   = 1'b1;
    key_raw = 3'b111;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].act);
      chk("tbl_level", int'(lvl_n), int'(tbl[i].lvl));
      chk("tbl_pulse", int'(pls_n), int'(tbl[i].pls));
    end

    // Auto-repeat on key 0: acceptance at edge 7, repeats at +10 then every 3.
    do_reset();
    pcount = 0;
    for (int s = 1; s <= 37; s++) begin
      step(3'b001);
      chk("rep_pulse0", int'(pls_r[0]),
          (s == 7 || (s >= 17 && (s - 17) % 3 == 0)) ? 1 : 0);
      chk("norep_pulse0", int'(pls_n[0]), (s == 7) ? 1 : 0);
      if (pls_n[0]) pcount++;
    end
    chk("norep_single_pulse", pcount, 1);
    chk("rep_level0_held", int'(lvl_r[0]), 1);

    // All three keys pressed on the same edge.
    do_reset();
    for (int s = 1; s <= 9; s++) begin
      step(3'b111);
      chk("simul_pulse_norep", int'(pls_n), (s == 7) ? 7 : 0);
      chk("simul_pulse_rep",   int'(pls_r), (s == 7) ? 7 : 0);
    end

    // Reset while key2 is held and key1 is mid-debounce (count 2).
    do_reset();
    for (int s = 1; s <= 4; s++) step(3'b100);
    for (int s = 5; s <= 9; s++) step(3'b110);
    chk("held_before_reset", int'(lvl_n[2]), 1);
    do_reset();
    pcount = 0;
    for (int s = 1; s <= 12; s++) begin
      step(3'b110);
      chk("post_reset_pulse", int'(pls_n), (s == 7) ? 6 : 0);
      if (pls_n[1]) pcount++;
    end
    chk("post_reset_one_pulse", pcount, 1);

    // Random run-length stimulus with occasional resets.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cur[k] = 0;
      run[k] = 0;
    end
    for (int i = 0; i < 600; i++) begin
      logic [2:0] act;
      if ($urandom_range(0, 199) == 0) do_reset();
      for (int k = 0; k < 3; k++) begin
        if (run[k] == 0) begin
          cur[k] = ~cur[k];
          run[k] = (k == 0) ? $urandom_range(1, 30) : $urandom_range(1, 12);
        end
        run[k]--;
        act[k] = cur[k];
      end
      step(act);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_press_conditioner.md
KEY_PRESS_CONDITIONER -- requirements
Module: key_press_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable-input cycles required to accept a press or release (1 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter KEY_ACTIVE_LOW, default 1; 1 means a raw key reads 0 when pressed.
REQ-003 Parameter REPEAT_EN, default 0; 1 enables auto-repeat pulses while a key is held.
REQ-004 Parameter REPEAT_DELAY_CYCLES, default 25000000, cycles from the accepted press to the first repeat pulse.
REQ-005 Parameter REPEAT_PERIOD_CYCLES, default 5000000, cycles between later repeat pulses.
REQ-006 Port: inclk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-007 Port: reset  input  1  asynchronous, active-high reset.
REQ-008 Port: key_raw  input  3  asynchronous push-button inputs; bit n is key n.
REQ-009 Port: key_level  output  3  debounced pressed state, 1 = pressed.
REQ-010 Port: key_pulse  output  3  one-cycle strobe per accepted press, plus repeat strobes; bit n drives key n of the speed-control stage.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchronizer and then be inverted when KEY_ACTIVE_LOW=1, giving a synchronized "active" signal.
REQ-012 Each key SHALL have its own independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus an up-counter of width $clog2(max of all cycle parameters)+1.
REQ-013 IDLE: when active=1, go to PRESS_WAIT and clear the counter; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: when active=0, return to IDLE and clear the counter; when active=1 and counter=DEBOUNCE_CYCLES-1, go to HELD, set key_level=1 and assert key_pulse for exactly one cycle; otherwise increment the counter.
REQ-015 Latency: with a clean press, key_pulse SHALL be high in the cycle that follows rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples the raw active level as edge 1.
REQ-016 HELD: when active=0, go to RELEASE_WAIT and clear the counter; in HELD, key_level SHALL remain 1.
REQ-017 HELD with REPEAT_EN=1: the counter counts while active; a key_pulse SHALL fire at count REPEAT_DELAY_CYCLES-1, then every REPEAT_PERIOD_CYCLES while the key stays in HELD.
REQ-018 HELD with REPEAT_EN=0: no further key_pulse SHALL be produced, however long the key is held.
REQ-019 RELEASE_WAIT: when active=1, return to HELD with no pulse, and the repeat timing restarts from REPEAT_DELAY; when active=0 and counter=DEBOUNCE_CYCLES-1, go to IDLE and set key_level=0; otherwise increment the counter.
REQ-020 The counter SHALL never wrap; every terminal compare resets or clears it before it can overflow.
REQ-021 Simultaneous events: keys are fully independent, and several key_pulse bits MAY be high in the same cycle; key priority belongs to the consumer.
REQ-022 key_pulse and key_level SHALL be driven directly from flops, with no combinational path from key_raw to any output.

Reset
REQ-023 While reset=1: all FSMs in IDLE, counters 0, synchronizer flops at the inactive level, key_level=3'b000, key_pulse=3'b000.
REQ-024 Reset asserted mid-operation, in any state, SHALL abort immediately with no pulse.
REQ-025 After reset is released, a key already held SHALL be treated as a new press and yield one pulse after the full debounce latency.

Structure
REQ-026 Package key_cond_pkg SHALL hold the FSM state enum (2-bit) and the constant NUM_KEYS=3.
REQ-027 Sub-module key_debounce_channel SHALL implement one synchronizer, FSM and counter, and SHALL be instantiated NUM_KEYS times via generate; the top level contains only wiring.

Verification
REQ-028 Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3, KEY_ACTIVE_LOW=1.
REQ-029 Scenario: key_raw[0] driven low and held -> key_pulse[0] high for exactly 1 cycle after edge 7, key_level[0]=1 from the same cycle, no further pulse with REPEAT_EN=0.
REQ-030 Scenario: key_raw[1] low for 3 cycles, high for 1, low for 3, then high -> no pulse, key_level[1] stays 0.
REQ-031 Scenario: key_raw[2] held, then released for 2 cycles, then pressed again -> exactly one pulse in total, key_level[2] never drops.
REQ-032 Scenario: REPEAT_EN=1, key 0 held for 30 cycles after acceptance -> pulses at acceptance, then at +10, +13, +16, +19, +22, +25, +28.
REQ-033 Scenario: all three keys pressed on the same edge -> key_pulse=3'b111 in a single cycle.
REQ-034 Scenario: reset asserted while key 1 is in PRESS_WAIT with count 2 -> outputs 0 immediately; after release with the key still held -> one pulse 7 edges later.
